// File: rtl/shift_pkg.sv
// shift_pkg: state encoding and default word width shared by the shift-path blocks.
package shift_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/shift_deser_core.sv
// shift_deser_core: shift register and bit counter with a one-cycle completion strobe.
module shift_deser_core
    import shift_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             shn,
    input  logic             clr,
    output logic             done,
    output logic [WIDTH-1:0] word,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, take;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end
    always_comb begin
        take    = shn && !clr;
        word    = MSB_FIRST ? {sr_q[WIDTH-2:0], sin} : {sin, sr_q[WIDTH-1:1]};
        done    = 1'b0;
        state_d = state_q;
        sr_d    = take ? word : sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (take) begin
                cnt_d   = CW'(1);
                state_d = SHIFT;
            end
            SHIFT: if (take) begin
                // the final bit completes the word on this edge; no separate done state
                done    = cnt_q == CW'(WIDTH - 1);
                cnt_d   = done ? '0 : cnt_q + CW'(1);
                state_d = done ? IDLE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            sr_d    = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end
        busy_d = cnt_d != '0;
    end
    assign busy = busy_q;
endmodule

// File: rtl/shift_deser.sv
// shift_deser: serial-to-parallel receiver with a valid/ready holding register and sticky overrun.
module shift_deser
    import shift_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             shn,
    input  logic             clr,
    input  logic             pready,
    output logic [WIDTH-1:0] pout,
    output logic             pvalid,
    output logic             busy,
    output logic             ovf
);
    logic             done, load;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pvalid_q, pvalid_d, ovf_q, ovf_d;
    shift_deser_core #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_core (
        .clk  (clk),
        .rst  (rst),
        .sin  (sin),
        .shn  (shn),
        .clr  (clr),
        .done (done),
        .word (word),
        .busy (busy)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pout_q   <= '0;
            pvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            pout_q   <= pout_d;
            pvalid_q <= pvalid_d;
            ovf_q    <= ovf_d;
        end
    end
    always_comb begin
        // a word may load into a slot that is being drained on the same edge
        load     = done && (!pvalid_q || pready);
        pout_d   = load ? word : pout_q;
        pvalid_d = load || (pvalid_q && !pready);
        ovf_d    = !clr && (ovf_q || (done && pvalid_q && !pready));
    end
    assign pout   = pout_q;
    assign pvalid = pvalid_q;
    assign ovf    = ovf_q;
endmodule

// File: tb/tb_shift_deser.sv
// tb_shift_deser: directed stimulus into MSB-first and LSB-first receivers checked against a word-level model.
module tb_shift_deser;
    localparam int W = 4;
    logic clk = 1'b0, rst = 1'b1, sin = 1'b0, shn = 1'b0, clr = 1'b0, pready = 1'b0;
    logic [W-1:0] pout_m, pout_l;
    logic pvalid_m, busy_m, ovf_m, pvalid_l, busy_l, ovf_l;
    int tests = 0, fails = 0;
    int m_cnt[2] = '{0, 0}, m_val[2] = '{0, 0}, m_pout[2] = '{0, 0};
    bit m_pv[2] = '{0, 0}, m_ovf[2] = '{0, 0}, m_busy[2] = '{0, 0};

    shift_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .sin(sin), .shn(shn), .clr(clr), .pready(pready),
        .pout(pout_m), .pvalid(pvalid_m), .busy(busy_m), .ovf(ovf_m));
    shift_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .sin(sin), .shn(shn), .clr(clr), .pready(pready),
        .pout(pout_l), .pvalid(pvalid_l), .busy(busy_l), .ovf(ovf_l));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // word-level model: index 0 is MSB-first, index 1 is LSB-first
    always @(posedge clk or posedge rst) begin
        bit done;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cnt[i] = 0; m_val[i] = 0; m_pout[i] = 0;
                m_pv[i] = 0; m_ovf[i] = 0; m_busy[i] = 0;
            end else begin
                done = 0;
                if (clr) begin
                    m_cnt[i] = 0; m_val[i] = 0; m_ovf[i] = 0;
                end else if (shn) begin
                    m_val[i] = (i == 0) ? m_val[i] * 2 + int'(sin) : m_val[i] + (int'(sin) << m_cnt[i]);
                    m_cnt[i]++;
                    done = m_cnt[i] == W;
                end
                if (done) begin
                    if (!m_pv[i] || pready) begin
                        m_pout[i] = m_val[i];
                        m_pv[i] = 1;
                    end else m_ovf[i] = 1;
                    m_cnt[i] = 0;
                    m_val[i] = 0;
                end else if (pready) m_pv[i] = 0;
                m_busy[i] = m_cnt[i] != 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("m.pout", int'(pout_m), m_pout[0]);
        chk("m.pvalid", int'(pvalid_m), int'(m_pv[0]));
        chk("m.busy", int'(busy_m), int'(m_busy[0]));
        chk("m.ovf", int'(ovf_m), int'(m_ovf[0]));
        chk("l.pout", int'(pout_l), m_pout[1]);
        chk("l.pvalid", int'(pvalid_l), int'(m_pv[1]));
        chk("l.busy", int'(busy_l), int'(m_busy[1]));
        chk("l.ovf", int'(ovf_l), int'(m_ovf[1]));
    end

    task automatic step(input logic s, input logic sh, input logic c, input logic pr);
        sin = s; shn = sh; clr = c; pready = pr;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] bits, input logic pr_last);
        for (int k = 3; k >= 0; k--) step(bits[k], 1'b1, 1'b0, (k == 0) ? pr_last : 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset pout", int'(pout_m), 0);
        chk("reset pvalid", int'(pvalid_m), 0);
        chk("reset busy", int'(busy_m), 0);
        chk("reset ovf", int'(ovf_m), 0);
        // basic word 1,0,1,0
        step(1, 1, 0, 0); chk("basic busy1", int'(busy_m), 1);
        step(0, 1, 0, 0); chk("basic busy2", int'(busy_m), 1);
        step(1, 1, 0, 0); chk("basic busy3", int'(busy_m), 1);
        step(0, 1, 0, 0); chk("basic busy4", int'(busy_m), 0);
        chk("basic pout", int'(pout_m), 'hA);
        chk("basic pvalid", int'(pvalid_m), 1);
        // pause in the middle of a word
        step(0, 0, 0, 1); chk("accept pvalid", int'(pvalid_m), 0);
        step(1, 1, 0, 0); step(1, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0);
            chk("pause busy", int'(busy_m), 1);
        end
        step(0, 1, 0, 0); step(0, 1, 0, 0);
        chk("pause pout", int'(pout_m), 'hC);
        chk("pause pvalid", int'(pvalid_m), 1);
        // overrun then clr
        step(0, 0, 0, 1);
        send(4'b1010, 1'b0);
        send(4'b0110, 1'b0);
        chk("ovf pout", int'(pout_m), 'hA);
        chk("ovf set", int'(ovf_m), 1);
        chk("ovf busy", int'(busy_m), 0);
        step(0, 0, 1, 0);
        chk("ovf clr", int'(ovf_m), 0);
        chk("clr keeps pvalid", int'(pvalid_m), 1);
        // simultaneous accept and completion
        send(4'b0011, 1'b1);
        chk("simul pout", int'(pout_m), 'h3);
        chk("simul pvalid", int'(pvalid_m), 1);
        chk("simul ovf", int'(ovf_m), 0);
        // asynchronous reset mid-word
        step(0, 0, 0, 1);
        step(1, 1, 0, 0); step(1, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("areset pout", int'(pout_m), 0);
        chk("areset pvalid", int'(pvalid_m), 0);
        chk("areset busy", int'(busy_m), 0);
        #1 rst = 1'b0;
        send(4'b1001, 1'b0);
        chk("post reset pout", int'(pout_m), 'h9);
        // LSB-first receiver
        step(0, 0, 0, 1);
        send(4'b1000, 1'b0);
        chk("lsb pout", int'(pout_l), 'h1);
        step(0, 0, 0, 1);
        step(1, 1, 0, 0); step(1, 1, 0, 0);
        step(0, 1, 1, 0);
        chk("lsb clr busy", int'(busy_l), 0);
        send(4'b0110, 1'b0);
        chk("lsb clr pout", int'(pout_l), 'h6);
        chk("lsb clr pvalid", int'(pvalid_l), 1);
        step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
